// File: rtl/button_bcd_counter.sv
// Debounced add/sub push buttons plus keypad digit entry driving a DIGITS-wide BCD up/down counter.
// Define BUTTON_AUTOREPEAT_EN for hold-to-repeat pulses; without it each debounced press yields one pulse.
module button_bcd_counter #(
  parameter int DIGITS          = 4,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter bit WRAP            = 1'b1,
  parameter int REPEAT_DELAY    = 50_000_000,
  parameter int REPEAT_PERIOD   = 10_000_000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pb_add,
  input  logic                  pb_sub,
  input  logic [3:0]            key,
  input  logic                  pressed,
  output logic [4*DIGITS-1:0]   digits,
  output logic                  add_pulse,
  output logic                  sub_pulse,
  output logic                  at_max,
  output logic                  at_min
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES);

  if (DIGITS < 1 || DIGITS > 8 || DEBOUNCE_CYCLES < 2 ||
      REPEAT_PERIOD < 1 || REPEAT_PERIOD > REPEAT_DELAY) begin : g_bad_params
    $error("button_bcd_counter: parameter out of range");
  end

  logic [1:0] raw;
  logic [1:0] pulse_w;

  assign raw       = {pb_sub, pb_add};
  assign add_pulse = pulse_w[0];
  assign sub_pulse = pulse_w[1];

  for (genvar b = 0; b < 2; b++) begin : g_btn
    logic          s1, s2, lvl, lvl_q, pulse;
    logic [DW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s1    <= 1'b0;
        s2    <= 1'b0;
        lvl   <= 1'b0;
        lvl_q <= 1'b0;
        cnt   <= '0;
      end else begin
        s1    <= raw[b];
        s2    <= s1;
        lvl_q <= lvl;
        if (s2 == lvl) begin
          cnt <= '0;
        end else if (cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
          lvl <= s2;
          cnt <= '0;
        end else begin
          cnt <= cnt + DW'(1);
        end
      end
    end

`ifdef BUTTON_AUTOREPEAT_EN
    localparam int RW = $clog2(REPEAT_DELAY + 1);
    logic [RW-1:0] rcnt;
    logic          fire;

    // rcnt holds cycles since the initial pulse; after each repeat it is rewound one period
    assign fire = lvl && (rcnt == RW'(REPEAT_DELAY));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rcnt  <= '0;
        pulse <= 1'b0;
      end else begin
        pulse <= (lvl & ~lvl_q) | fire;
        if (!lvl)
          rcnt <= '0;
        else if (!lvl_q)
          rcnt <= RW'(1);
        else if (fire)
          rcnt <= RW'(REPEAT_DELAY - REPEAT_PERIOD + 1);
        else
          rcnt <= rcnt + RW'(1);
      end
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pulse <= 1'b0;
      else        pulse <= lvl & ~lvl_q;
    end
`endif

    assign pulse_w[b] = pulse;
  end

  logic       pressed_q;
  logic       key_vld;
  logic [3:0] key_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pressed_q <= 1'b0;
      key_vld   <= 1'b0;
      key_q     <= 4'd0;
    end else begin
      pressed_q <= pressed;
      key_vld   <= pressed & ~pressed_q & (key <= 4'd9);
      key_q     <= key;
    end
  end

  function automatic logic [4*DIGITS-1:0] bcd_step(input logic [4*DIGITS-1:0] v, input logic up);
    logic [4*DIGITS-1:0] r;
    logic                c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (c) begin
        if (up) begin
          if (r[4*i +: 4] == 4'd9) r[4*i +: 4] = 4'd0;
          else begin
            r[4*i +: 4] = r[4*i +: 4] + 4'd1;
            c = 1'b0;
          end
        end else begin
          if (r[4*i +: 4] == 4'd0) r[4*i +: 4] = 4'd9;
          else begin
            r[4*i +: 4] = r[4*i +: 4] - 4'd1;
            c = 1'b0;
          end
        end
      end
    end
    return r;
  endfunction

  logic [4*DIGITS-1:0] shifted;

  always_comb begin
    shifted      = digits << 4;
    shifted[3:0] = key_q;
  end

  assign at_max = (digits == {DIGITS{4'd9}});
  assign at_min = (digits == '0);

  // Keypad entry wins; a pulse that loses arbitration this cycle is simply dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digits <= '0;
    end else if (key_vld) begin
      digits <= shifted;
    end else if (add_pulse && sub_pulse) begin
      digits <= digits;
    end else if (add_pulse) begin
      if (WRAP || !at_max) digits <= bcd_step(digits, 1'b1);
    end else if (sub_pulse) begin
      if (WRAP || !at_min) digits <= bcd_step(digits, 1'b0);
    end
  end

endmodule

// File: tb/tb_button_bcd_counter.sv
// Bench for button_bcd_counter: wrapping and saturating instances against a window/arithmetic reference model.
module tb_button_bcd_counter;
  localparam int DB   = 4;
  localparam int RD   = 20;
  localparam int RP   = 5;
  localparam int MAXV = 9999;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        pb_add = 1'b0, pb_sub = 1'b0, pressed = 1'b0;
  logic [3:0]  key = 4'd0;
  logic [15:0] dig_w, dig_s;
  logic        addp_w, subp_w, amax_w, amin_w;
  logic        addp_s, subp_s, amax_s, amin_s;

  button_bcd_counter #(.DIGITS(4), .DEBOUNCE_CYCLES(DB), .WRAP(1'b1),
                       .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .pb_add(pb_add), .pb_sub(pb_sub), .key(key), .pressed(pressed),
    .digits(dig_w), .add_pulse(addp_w), .sub_pulse(subp_w), .at_max(amax_w), .at_min(amin_w));

  button_bcd_counter #(.DIGITS(4), .DEBOUNCE_CYCLES(DB), .WRAP(1'b0),
                       .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut_sat (
    .clk(clk), .rst_n(rst_n), .pb_add(pb_add), .pb_sub(pb_sub), .key(key), .pressed(pressed),
    .digits(dig_s), .add_pulse(addp_s), .sub_pulse(subp_s), .at_max(amax_s), .at_min(amin_s));

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int cyc = 0;
  int n_add = 0, n_sub = 0, first_add = -1;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: raw-sample windows for debounce, integer arithmetic for the counter
  bit ha[0:DB], hs[0:DB];
  bit la1, la2, ls1, ls2, m_add, m_sub, m_kev, m_prp, ona, ons;
  int m_key, v_w, v_s, n_edge, t0a, t0s;

  function automatic int step(int v, bit kev, int k, bit a, bit s, bit wrap);
    if (kev) return (v * 10) % 10000 + k;
    if (a && s) return v;
    if (a) return (v == MAXV) ? (wrap ? 0 : MAXV) : v + 1;
    if (s) return (v == 0) ? (wrap ? MAXV : 0) : v - 1;
    return v;
  endfunction

  function automatic int bcd_int(input logic [15:0] b);
    int r = 0;
    for (int i = 3; i >= 0; i--) begin
      if (b[4*i +: 4] > 4'd9) return -1;
      r = r * 10 + int'(b[4*i +: 4]);
    end
    return r;
  endfunction

  task automatic model_reset();
    for (int j = 0; j <= DB; j++) begin ha[j] = 1'b0; hs[j] = 1'b0; end
    la1 = 0; la2 = 0; ls1 = 0; ls2 = 0; m_add = 0; m_sub = 0; m_kev = 0; m_prp = 0;
    ona = 0; ons = 0; m_key = 0; v_w = 0; v_s = 0;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_reset();
    end else begin
      bit ra, rs, fa, fs;
      v_w = step(v_w, m_kev, m_key, m_add, m_sub, 1'b1);
      v_s = step(v_s, m_kev, m_key, m_add, m_sub, 1'b0);
      n_edge++;
      ra = la1 & ~la2;
      rs = ls1 & ~ls2;
`ifdef BUTTON_AUTOREPEAT_EN
      if (!la1) ona = 0;
      if (!ls1) ons = 0;
      if (ra) begin ona = 1; t0a = n_edge; end
      else if (ona && n_edge - t0a >= RD && (n_edge - t0a - RD) % RP == 0) ra = 1;
      if (rs) begin ons = 1; t0s = n_edge; end
      else if (ons && n_edge - t0s >= RD && (n_edge - t0s - RD) % RP == 0) rs = 1;
`endif
      m_add = ra;
      m_sub = rs;
      m_kev = pressed && !m_prp && (key <= 4'd9);
      m_key = int'(key);
      m_prp = pressed;
      // Level flips once the last DB synchronised samples all disagree with it
      fa = 1; fs = 1;
      for (int j = 1; j <= DB; j++) begin
        if (ha[j] == la1) fa = 0;
        if (hs[j] == ls1) fs = 0;
      end
      la2 = la1; la1 = fa ? ~la1 : la1;
      ls2 = ls1; ls1 = fs ? ~ls1 : ls1;
      for (int j = DB; j >= 1; j--) begin ha[j] = ha[j-1]; hs[j] = hs[j-1]; end
      ha[0] = pb_add;
      hs[0] = pb_sub;
    end
  end

  always @(negedge clk) begin
    checks++;
    if (bcd_int(dig_w) != v_w || addp_w != m_add || subp_w != m_sub ||
        amax_w != (v_w == MAXV) || amin_w != (v_w == 0)) begin
      errors++;
      $display("FAIL model_wrap cyc %0d: digits %h add %b sub %b max %b min %b, want %0d add %b sub %b max %b min %b",
               cyc, dig_w, addp_w, subp_w, amax_w, amin_w, v_w, m_add, m_sub, v_w == MAXV, v_w == 0);
    end
    checks++;
    if (bcd_int(dig_s) != v_s || addp_s != m_add || subp_s != m_sub ||
        amax_s != (v_s == MAXV) || amin_s != (v_s == 0)) begin
      errors++;
      $display("FAIL model_sat cyc %0d: digits %h add %b sub %b max %b min %b, want %0d add %b sub %b max %b min %b",
               cyc, dig_s, addp_s, subp_s, amax_s, amin_s, v_s, m_add, m_sub, v_s == MAXV, v_s == 0);
    end
    if (addp_w) begin n_add++; if (first_add < 0) first_add = cyc; end
    if (subp_w) n_sub++;
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic hold(input bit a, input bit s, input int n);
    pb_add = a; pb_sub = s;
    repeat (n) @(negedge clk);
    pb_add = 0; pb_sub = 0;
    repeat (DB + 8) @(negedge clk);
  endtask

  task automatic keyin(input int k);
    key = 4'(k); pressed = 1;
    @(negedge clk);
    pressed = 0;
    @(negedge clk);
  endtask

  task automatic preload(input int v);
    keyin(v / 1000 % 10); keyin(v / 100 % 10); keyin(v / 10 % 10); keyin(v % 10);
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_dig_w"}, int'(dig_w), 0);
    check({name, "_dig_s"}, int'(dig_s), 0);
    check({name, "_pulses"}, int'({addp_w, subp_w, addp_s, subp_s}), 0);
    check({name, "_min_max"}, int'({amin_w, amax_w}), 2);
  endtask

  initial begin
    int start;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1;
    @(negedge clk);

    // Clean press
    n_add = 0; first_add = -1; start = cyc;
    hold(1, 0, 20);
    check("clean_count", n_add, 1);
    check("clean_latency", first_add - start, 7);
    check("clean_digits", int'(dig_w), 'h0001);

    // Bounce shorter than the debounce window
    n_add = 0;
    for (int i = 0; i < 20; i++) begin
      if (i % 2 == 0) pb_add = ~pb_add;
      @(negedge clk);
    end
    pb_add = 0;
    repeat (12) @(negedge clk);
    check("bounce_count", n_add, 0);
    check("bounce_digits", int'(dig_w), 'h0001);

    // Carry, wrap and saturation
    preload(99);
    check("preload_99", int'(dig_w), 'h0099);
    hold(1, 0, 8);
    check("carry_0100", int'(dig_w), 'h0100);
    preload(9999);
    check("at_max_9999", int'(amax_w), 1);
    hold(1, 0, 8);
    check("wrap_up", int'(dig_w), 'h0000);
    check("sat_up", int'(dig_s), 'h9999);
    preload(0);
    hold(0, 1, 8);
    check("wrap_down", int'(dig_w), 'h9999);
    check("sat_down", int'(dig_s), 'h0000);
    check("sat_down_min", int'(amin_s), 1);

    // Priority
    preload(1234);
    hold(1, 1, 8);
    check("add_sub_same", int'(dig_w), 'h1234);
    preload(12);
    pb_add = 1;
    repeat (6) @(negedge clk);
    key = 4'd7; pressed = 1;
    @(negedge clk);
    pressed = 0;
    repeat (3) @(negedge clk);
    pb_add = 0;
    repeat (12) @(negedge clk);
    check("key_beats_add", int'(dig_w), 'h0127);
    keyin(12);
    @(negedge clk);
    check("key_12_ignored", int'(dig_w), 'h0127);

    // Reset during debounce count 3
    n_add = 0;
    pb_add = 1;
    repeat (5) @(negedge clk);
    #2 rst_n = 0;
    #1 check_reset_outputs("rst_debounce");
    pb_add = 0;
    @(negedge clk);
    rst_n = 1;
    repeat (20) @(negedge clk);
    check("rst_debounce_nopulse", n_add, 0);

    // Reset during a pulse cycle
    preload(55);
    n_add = 0;
    pb_add = 1;
    for (int i = 0; i < 20 && !addp_w; i++) @(negedge clk);
    check("pulse_seen", int'(addp_w), 1);
    #2 rst_n = 0;
    #1 check_reset_outputs("rst_pulse");
    pb_add = 0;
    @(negedge clk);
    rst_n = 1;
    repeat (20) @(negedge clk);
    check("rst_pulse_nopulse", n_add, 1);
    hold(1, 0, 8);
    check("after_rst_press", int'(dig_w), 'h0001);

    // Long hold of sub from 0010
    preload(10);
    n_sub = 0;
    hold(0, 1, 60);
`ifdef BUTTON_AUTOREPEAT_EN
    check("hold_pulses", n_sub, 9);
    check("hold_digits", int'(dig_w), 'h0001);
    check("hold_model", v_w, 1);
`else
    check("hold_pulses", n_sub, 1);
    check("hold_digits", int'(dig_w), 'h0009);
    check("hold_model", v_w, 9);
`endif

    // Randomised traffic against the model
    for (int it = 0; it < 150; it++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r <= 4) begin
        pb_add = 1'($urandom_range(0, 1));
        pb_sub = 1'($urandom_range(0, 1));
        repeat ($urandom_range(1, 40)) begin
          @(negedge clk);
          if ($urandom_range(0, 7) == 0) pb_add = ~pb_add;
          if ($urandom_range(0, 7) == 0) pb_sub = ~pb_sub;
        end
        pb_add = 0; pb_sub = 0;
        repeat ($urandom_range(0, 10)) @(negedge clk);
      end else if (r <= 7) begin
        key = 4'($urandom_range(0, 15)); pressed = 1;
        repeat ($urandom_range(1, 3)) @(negedge clk);
        pressed = 0;
        @(negedge clk);
      end else if (r == 8) begin
        pb_add = 1'($urandom_range(0, 1));
        #($urandom_range(1, 4)) rst_n = 0;
        #1 check("rand_rst_digits", int'({dig_w, dig_s}), 0);
        repeat ($urandom_range(1, 3)) @(negedge clk);
        rst_n = 1;
      end else begin
        repeat ($urandom_range(1, 20)) @(negedge clk);
      end
    end
    pb_add = 0; pb_sub = 0; pressed = 0;
    repeat (20) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
